// File: rtl/synth_pkg.sv
// Shared constants and FSM state type for the SPI control register slice.
package synth_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = 6;

  localparam logic [ADDR_W-1:0] ADDR_ADSR   = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_OSC    = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_FILTER = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'h03;

  localparam int unsigned MUTE_BIT = 0;
  localparam int unsigned TRIG_BIT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDone,
    StCommit
  } spi_state_e;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for one raw pin, plus one extra flop for rise/fall detection.
module pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_regs_sync.sv
// Oversampled SPI slave and synth control registers; 40-bit frames commit on nss rise.
// Optional register readback on spi_miso is enabled by defining SPI_READBACK_EN.
module spi_regs_sync
  import synth_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [31:0] OSC_COUNT_RST = 32'd46545,
  parameter logic [31:0] ADSR_RST      = 32'h10_10_80_10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_nss,
  output logic [7:0]  adsr_ai,
  output logic [7:0]  adsr_di,
  output logic [7:0]  adsr_s,
  output logic [7:0]  adsr_ri,
  output logic [31:0] osc_count,
  output logic [7:0]  filter_a,
  output logic [7:0]  filter_b,
  output logic        mute,
  output logic        trig,
  output logic        frame_err
`ifdef SPI_READBACK_EN
  ,
  output logic        spi_miso
`endif
);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic nss_lvl, nss_rise, nss_fall;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (spi_clk),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (spi_mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  // nss idles high, so its chain resets high to avoid a false edge on reset release.
  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (spi_nss),
    .level_o (nss_lvl),
    .rise_o  (nss_rise),
    .fall_o  (nss_fall)
  );

  logic unused_pins;
  assign unused_pins = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall, nss_lvl};

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               overrun_q, overrun_d;
  logic               short_err, commit_go, load_rd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    short_err = 1'b0;
    commit_go = 1'b0;
    load_rd   = 1'b0;
    if (nss_fall) begin
      // A new select restarts the frame from any state, discarding what was collected.
      state_d   = StAddr;
      cnt_d     = '0;
      shift_d   = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StData: begin
          if (nss_rise) begin
            short_err = 1'b1;
            state_d   = StIdle;
          end else if (sck_rise) begin
            shift_d = {shift_q[FRAME_W-2:0], mosi_lvl};
            cnt_d   = cnt_q + 1'b1;
            if (state_q == StAddr && cnt_q == CNT_W'(ADDR_W - 1)) begin
              state_d = StData;
              load_rd = 1'b1;
            end
            if (state_q == StData && cnt_q == CNT_W'(FRAME_W - 1)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (nss_rise) begin
            state_d = StCommit;
          end else if (sck_rise) begin
            overrun_d = 1'b1;
          end
        end
        StCommit: begin
          commit_go = 1'b1;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
    end
  end

  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              is_read, addr_ok, frame_bad, wr_en, err_d;

  assign frame_addr = shift_q[FRAME_W-1:DATA_W];
  assign frame_data = shift_q[DATA_W-1:0];

`ifdef SPI_READBACK_EN
  assign is_read = frame_addr[7];
  assign addr_ok = (frame_addr[6:0] <= ADDR_CTRL[6:0]);
`else
  assign is_read = 1'b0;
  assign addr_ok = (frame_addr <= ADDR_CTRL);
`endif

  assign frame_bad = overrun_q | ~addr_ok;
  assign wr_en     = commit_go & ~frame_bad & ~is_read;
  assign err_d     = short_err | (commit_go & frame_bad);

  logic [31:0] adsr_q, osc_q;
  logic [15:0] filt_q;
  logic        mute_q, trig_q, err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adsr_q <= ADSR_RST;
      osc_q  <= OSC_COUNT_RST;
      filt_q <= '0;
      mute_q <= 1'b1;
      trig_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      err_q  <= err_d;
      if (wr_en) begin
        case (frame_addr)
          ADDR_ADSR:   adsr_q <= frame_data;
          ADDR_OSC:    osc_q  <= frame_data;
          ADDR_FILTER: filt_q <= frame_data[15:0];
          ADDR_CTRL: begin
            mute_q <= frame_data[MUTE_BIT];
            trig_q <= frame_data[TRIG_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  assign adsr_ai   = adsr_q[31:24];
  assign adsr_di   = adsr_q[23:16];
  assign adsr_s    = adsr_q[15:8];
  assign adsr_ri   = adsr_q[7:0];
  assign osc_count = osc_q;
  assign filter_a  = filt_q[15:8];
  assign filter_b  = filt_q[7:0];
  assign mute      = mute_q;
  assign trig      = trig_q;
  assign frame_err = err_q;

`ifdef SPI_READBACK_EN
  logic [6:0]  rd_addr;
  logic        rd_req;
  logic [31:0] rd_value;
  logic [31:0] out_q;
  logic        miso_q;

  // Address byte completes on this sck_rise, so its last bit is still in mosi_lvl.
  assign rd_req  = shift_q[6];
  assign rd_addr = {shift_q[5:0], mosi_lvl};

  always_comb begin
    rd_value = '0;
    case (rd_addr)
      ADDR_ADSR[6:0]:   rd_value = adsr_q;
      ADDR_OSC[6:0]:    rd_value = osc_q;
      ADDR_FILTER[6:0]: rd_value = {16'h0000, filt_q};
      ADDR_CTRL[6:0]:   rd_value = {31'h0, mute_q};
      default:          rd_value = '0;
    endcase
  end

  // Each sck_fall in DATA presents the next bit, so the master samples it on the following rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      miso_q <= 1'b0;
    end else if (nss_lvl) begin
      out_q  <= '0;
      miso_q <= 1'b0;
    end else if (load_rd) begin
      out_q <= rd_req ? rd_value : 32'h0;
    end else if (sck_fall && state_q == StData) begin
      miso_q <= out_q[31];
      out_q  <= {out_q[30:0], 1'b0};
    end
  end

  assign spi_miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_regs_sync.sv
// Directed bench for spi_regs_sync with a frame-level model checked every clock.
module tb_spi_regs_sync;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 4;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_nss = 1'b1;
  logic [7:0] adsr_ai, adsr_di, adsr_s, adsr_ri, filter_a, filter_b;
  logic [31:0] osc_count;
  logic mute, trig, frame_err, miso_w;

  always #5 clk = ~clk;

  spi_regs_sync #(
    .SYNC_STAGES   (SYNC),
    .OSC_COUNT_RST (32'd46545),
    .ADSR_RST      (32'h10_10_80_10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_nss   (spi_nss),
    .adsr_ai   (adsr_ai),
    .adsr_di   (adsr_di),
    .adsr_s    (adsr_s),
    .adsr_ri   (adsr_ri),
    .osc_count (osc_count),
    .filter_a  (filter_a),
    .filter_b  (filter_b),
    .mute      (mute),
    .trig      (trig),
    .frame_err (frame_err)
`ifdef SPI_READBACK_EN
    ,
    .spi_miso  (miso_w)
`endif
  );

`ifndef SPI_READBACK_EN
  assign miso_w = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: register contents plus pending frame outcomes with their due cycles.
  typedef struct {
    int          due;
    bit          upd;
    bit          err;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] m_adsr, m_osc;
  logic [15:0] m_filt;
  logic        m_mute, e_trig, e_err;
  bit          chk_en = 1'b0;

  task automatic m_reset();
    m_adsr = 32'h10108010;
    m_osc  = 32'd46545;
    m_filt = 16'h0000;
    m_mute = 1'b1;
    evq.delete();
  endtask

  // Outcome of a frame whose nss rose (at the pin) after the negedge of cycle r.
  task automatic m_frame(input logic [7:0] addr, input logic [31:0] data, input int nbits,
                         input int r);
    ev_t ev;
    ev.addr = addr;
    ev.data = data;
    ev.upd  = 1'b0;
    ev.err  = 1'b0;
    ev.due  = r + SYNC + 2;
    if (nbits < 40) begin
      ev.err = 1'b1;
      ev.due = r + SYNC + 1;  // aborted frames are flagged on detection, not at commit
    end else if (nbits > 40) begin
      ev.err = 1'b1;
    end else if (RB && addr[7]) begin
      ev.err = (addr[6:0] > 7'd3);
    end else if (addr > 8'd3) begin
      ev.err = 1'b1;
    end else begin
      ev.upd = 1'b1;
    end
    evq.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_trig = 1'b0;
      e_err  = 1'b0;
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        if (evq[0].err) e_err = 1'b1;
        if (evq[0].upd) begin
          case (evq[0].addr)
            8'd0: m_adsr = evq[0].data;
            8'd1: m_osc = evq[0].data;
            8'd2: m_filt = evq[0].data[15:0];
            default: begin
              m_mute = evq[0].data[0];
              e_trig = evq[0].data[1];
            end
          endcase
        end
        void'(evq.pop_front());
      end
      check("adsr", {adsr_ai, adsr_di, adsr_s, adsr_ri}, m_adsr);
      check("osc_count", osc_count, m_osc);
      check("filter", {filter_a, filter_b}, {16'h0, m_filt});
      check("mute", mute, m_mute);
      check("trig", trig, e_trig);
      check("frame_err", frame_err, e_err);
    end
  end

  int trig_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (trig) trig_cnt <= trig_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // Sends nbits at clk/8, MSB first; abort_at >= 0 asserts reset at that bit instead.
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input int nbits,
                            input int abort_at, output logic [39:0] cap);
    logic [39:0] fr;
    fr  = {addr, data};
    cap = '0;
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check("rst_async_osc", osc_count, 32'd46545);
        check("rst_async_adsr", {adsr_ai, adsr_di, adsr_s, adsr_ri}, 32'h10108010);
        check("rst_async_mute", mute, 1'b1);
        spi_nss  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        return;
      end
      spi_mosi = (i < 40) ? fr[39-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      cap = {cap[38:0], miso_w};
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_nss  = 1'b1;
    spi_mosi = 1'b0;
    m_frame(addr, data, nbits, cyc);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] cap;
    m_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_osc", osc_count, 32'd46545);
    check("rst_mute", mute, 1'b1);
    check("rst_adsr_s", adsr_s, 8'h80);
    check("rst_trig", trig, 1'b0);
    check("rst_err", frame_err, 1'b0);

    send_frame(8'h01, 32'h0000B5D0, 40, -1, cap);
    check("osc_write", osc_count, 32'd46544);

    send_frame(8'h03, 32'h00000002, 40, -1, cap);
    check("trig_once", trig_cnt, 1);
    check("mute_clear", mute, 1'b0);
    send_frame(8'h03, 32'h00000001, 40, -1, cap);
    check("no_trig", trig_cnt, 1);
    check("mute_set", mute, 1'b1);

    send_frame(8'h02, 32'hFFFFAB12, 20, -1, cap);
    check("short_err", err_cnt, 1);
    check("short_filter", {filter_a, filter_b}, 16'h0000);
    send_frame(8'h00, 32'hDEADBEEF, 41, -1, cap);
    check("overrun_err", err_cnt, 2);
    send_frame(8'h07, 32'h12345678, 40, -1, cap);
    check("badaddr_err", err_cnt, 3);
    check("badaddr_adsr", {adsr_ai, adsr_di, adsr_s, adsr_ri}, 32'h10108010);

    send_frame(8'h02, 32'hFFFFAB12, 40, -1, cap);
    check("filter_a", filter_a, 8'hAB);
    check("filter_b", filter_b, 8'h12);

    send_frame(8'h00, 32'h55667788, 40, 30, cap);
    check("post_rst_filter", {filter_a, filter_b}, 16'h0000);
    send_frame(8'h00, 32'h01020304, 40, -1, cap);
    check("adsr_ai", adsr_ai, 8'd1);
    check("adsr_di", adsr_di, 8'd2);
    check("adsr_s", adsr_s, 8'd3);
    check("adsr_ri", adsr_ri, 8'd4);

`ifdef SPI_READBACK_EN
    send_frame(8'h02, 32'h0000AB12, 40, -1, cap);
    send_frame(8'h82, 32'h00000000, 40, -1, cap);
    check("readback", cap[31:0], 32'h0000AB12);
    check("read_no_err", err_cnt, 3);
    check("miso_idle", miso_w, 1'b0);
    send_frame(8'h85, 32'h00000000, 40, -1, cap);
    check("read_bad_data", cap[31:0], 32'h0);
    check("read_bad_err", err_cnt, 4);
`else
    send_frame(8'h82, 32'h00000055, 40, -1, cap);
    check("bit7_err", err_cnt, 4);
`endif

    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_regs_sync.md
Name: spi_regs_sync

Overview:
- System-clock-domain SPI slave and control register file; drives the `synth` configuration inputs (adsr_*, osc_count, filter_*) plus mute and trig.
- Oversamples raw spi_clk/spi_mosi/spi_nss pins on clk, so it has no second clock domain.
- Decodes 40-bit write frames and commits them atomically on frame end.
- Sits directly upstream of `synth` inside `synth_top`.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per SPI input pin (min 2).
- OSC_COUNT_RST, 32'd46545, reset value of osc_count (440 Hz at 20.48 MHz).
- ADSR_RST, 32'h10_10_80_10, reset value of the packed {ai,di,s,ri} register.

Ports:
- clk  in  1  system clock, 20.48 MHz
- rst  in  1  reset; asynchronous assert, active-low, synchronously released upstream
- spi_clk  in  1  raw SPI clock pin, mode 0, max clk/8
- spi_mosi  in  1  raw SPI data pin, MSB first
- spi_nss  in  1  raw chip select, active-low
- adsr_ai  out  8  attack increment, ADSR reg [31:24]
- adsr_di  out  8  decay increment, [23:16]
- adsr_s  out  8  sustain level, [15:8]
- adsr_ri  out  8  release increment, [7:0]
- osc_count  out  32  oscillator period count
- filter_a  out  8  FILTER reg [15:8]
- filter_b  out  8  FILTER reg [7:0]
- mute  out  1  CTRL bit0, level
- trig  out  1  one-clk pulse when a CTRL write has bit1 set
- frame_err  out  1  one-clk pulse on an aborted or malformed frame

Behaviour:
- Reset values (rst low, asynchronous):
  - ADSR = ADSR_RST; osc_count = OSC_COUNT_RST; filter_a = 0; filter_b = 0.
  - mute = 1; trig = 0; frame_err = 0.
  - FSM in IDLE; shift register and bit counter cleared.
- Synchronization and edge detection:
  - Each pin passes through SYNC_STAGES flops.
  - One further flop per pin gives edge detect: sck_rise, nss_fall, nss_rise.
- Frame format: 8-bit address, then 32-bit data, MSB first; mosi sampled on sck_rise.
- Address map: 0x00 ADSR, 0x01 OSC_COUNT, 0x02 FILTER (bits [31:16] ignored), 0x03 CTRL. Any other address is decoded as an error.
- FSM states and transitions:
  - IDLE: on nss_fall -> ADDR; clear the counter.
  - ADDR: shift on sck_rise; after 8 bits -> DATA.
  - DATA: shift on sck_rise; after 32 bits -> DONE.
  - DONE: further sck_rise -> overrun flag set; on nss_rise -> COMMIT.
  - COMMIT: one clock, then -> IDLE.
- Commit rules:
  - Register update happens in the COMMIT clock, so outputs change 1 clk after nss_rise is detected.
  - Total pin-to-output latency is SYNC_STAGES+2 clk after the physical nss rise.
  - trig pulses in the same COMMIT cycle as the CTRL write; exactly one clock high.
  - A CTRL write with bit1 = 0 updates mute only.
- Error conditions, each giving frame_err = 1 for one clk, no register change, return to IDLE:
  - nss_rise while in ADDR or DATA (short frame).
  - Overrun (more than 40 bits).
  - Unknown address.
- Event priority:
  - nss_rise and sck_rise in the same clk: the sck edge is ignored.
  - nss_fall while not in IDLE: restart at ADDR; no commit, no error.
- Reset mid-frame: all registers return to reset values immediately; the partial frame is discarded.
- Output stability: outputs are registered and never glitch; all fields of a 32-bit register update in the same clk.

Optional Feature:
- Macro: SPI_READBACK_EN.
- When defined:
  - Adds output port `spi_miso` (1 bit), driven by a clk-domain register.
  - Address bit7 = 1 marks a read of register addr[6:0].
  - On the 8th address bit, the register value is loaded into an out-shifter.
  - The out-shifter shifts on sck_fall (detected in the clk domain) during DATA, MSB first.
  - Read frames never commit. Unknown read addresses return 0 and pulse frame_err.
  - spi_miso = 0 while nss is high.
- When undefined:
  - No spi_miso port.
  - Address bit7 = 1 is treated as an unknown address and raises frame_err.

Decomposition:
- Package `synth_pkg` holds:
  - Address constants ADDR_ADSR, ADDR_OSC, ADDR_FILTER, ADDR_CTRL.
  - FSM state enum.
  - Frame widths ADDR_W = 8, DATA_W = 32.
  - CTRL bit indices MUTE_BIT = 0, TRIG_BIT = 1.
- Sub-module `pin_sync`: parameterized SYNC_STAGES synchronizer plus rise/fall edge detect, instantiated once per SPI pin.

Test Plan:
- Reset release, no SPI activity -> osc_count = 46545, mute = 1, adsr_s = 8'h80, trig = 0, frame_err = 0.
- Frame 0x01 / 0x0000B5D0, spi_clk = clk/8 -> osc_count = 46544 exactly SYNC_STAGES+2 clk after nss rise; no other output changes.
- Frame 0x03 / 0x00000002 -> trig high for exactly 1 clk, mute = 0; then write 0x03 / 0x00000001 -> mute = 1, no trig.
- nss raised after 20 bits (addr 0x02) -> frame_err 1-clk pulse; filter_a and filter_b unchanged. 41-bit frame -> frame_err; address 0x07 -> frame_err.
- rst asserted at bit 30 of an ADSR write -> outputs return to reset values asynchronously; the next full frame 0x00 / 0x01020304 yields ai = 1, di = 2, s = 3, ri = 4.
- SPI_READBACK_EN: write 0x02 / 0x0000AB12, then read frame 0x82 -> spi_miso carries 0x0000AB12 MSB first; no register changes.
